uart_rx: RTL



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, receiver state encoding and timing helpers.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_IDX_W     = $clog2(UART_DATA_BITS);

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t RX_IDLE    = 3'd0;
    localparam rx_state_t RX_START   = 3'd1;
    localparam rx_state_t RX_DATA    = 3'd2;
    localparam rx_state_t RX_STOP    = 3'd3;
    localparam rx_state_t RX_CLEANUP = 3'd4;

    // Offset from start-bit detection to the start-bit midpoint sample.
    function automatic int unsigned half_bit(input int unsigned clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with configurable reset value.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_Async;
            r_sync <= r_meta;
        end
    end

    assign o_Sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: midpoint-sampled bits, one-cycle valid strobe and framing-error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_Rx_Serial,
    output logic                      o_Rx_DV,
    output logic [UART_DATA_BITS-1:0] o_Rx_Byte,
    output logic                      o_Rx_Active,
    output logic                      o_Frame_Err
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_I = half_bit(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_I);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(UART_DATA_BITS - 1);

    logic w_rx_s;

    rx_state_t                 r_state,   w_state;
    logic [CNT_W-1:0]          r_clk_cnt, w_clk_cnt;
    logic [UART_IDX_W-1:0]     r_bit_idx, w_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift,   w_shift;
    logic [UART_DATA_BITS-1:0] r_byte,    w_byte;
    logic                      r_dv,      w_dv;
    logic                      r_fe,      w_fe;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Async (i_Rx_Serial),
        .o_Sync  (w_rx_s)
    );

    always_comb begin
        w_state   = r_state;
        w_clk_cnt = r_clk_cnt;
        w_bit_idx = r_bit_idx;
        w_shift   = r_shift;
        w_byte    = r_byte;
        w_dv      = 1'b0;
        w_fe      = 1'b0;

        case (r_state)
            RX_IDLE: begin
                w_clk_cnt = '0;
                if (!w_rx_s) begin
                    w_state = RX_START;
                end
            end

            RX_START: begin
                if (r_clk_cnt == CNT_HALF) begin
                    w_clk_cnt = '0;
                    // A start bit that is gone by its midpoint was a glitch.
                    if (!w_rx_s) begin
                        w_state   = RX_DATA;
                        w_bit_idx = '0;
                    end else begin
                        w_state = RX_IDLE;
                    end
                end else begin
                    w_clk_cnt = r_clk_cnt + CNT_W'(1);
                end
            end

            RX_DATA: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_clk_cnt          = '0;
                    w_shift[r_bit_idx] = w_rx_s;
                    w_bit_idx          = r_bit_idx + UART_IDX_W'(1);
                    if (r_bit_idx == IDX_LAST) begin
                        w_state = RX_STOP;
                    end
                end else begin
                    w_clk_cnt = r_clk_cnt + CNT_W'(1);
                end
            end

            RX_STOP: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_clk_cnt = '0;
                    w_state   = RX_CLEANUP;
                    if (w_rx_s) begin
                        w_dv   = 1'b1;
                        w_byte = r_shift;
                    end else begin
                        w_fe = 1'b1;
                    end
                end else begin
                    w_clk_cnt = r_clk_cnt + CNT_W'(1);
                end
            end

            RX_CLEANUP: begin
                // Wait out a break or stuck-low line before hunting for a new start bit.
                if (w_rx_s) begin
                    w_state = RX_IDLE;
                end
            end

            default: begin
                w_state = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state   <= RX_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_dv      <= 1'b0;
            r_fe      <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_clk_cnt <= w_clk_cnt;
            r_bit_idx <= w_bit_idx;
            r_shift   <= w_shift;
            r_byte    <= w_byte;
            r_dv      <= w_dv;
            r_fe      <= w_fe;
        end
    end

    assign o_Rx_DV     = r_dv;
    assign o_Rx_Byte   = r_byte;
    assign o_Rx_Active = (r_state != RX_IDLE);
    assign o_Frame_Err = r_fe;

endmodule
